// File: rtl/switch_bank_debouncer_if.sv
// Switch bank bus: raw panel contacts and fault clear in, conditioned levels, pulses and faults out.
interface switch_bank_debouncer_if #(
   parameter int unsigned CHANNELS = 7
);
   logic [CHANNELS-1:0] sw_high_n;
   logic [CHANNELS-1:0] sw_low_n;
   logic                fault_clear;
   logic [CHANNELS-1:0] state;
   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] fall;
   logic [CHANNELS-1:0] fault;
   logic                tick;

   // Panel side: drives contacts and fault clear, consumes conditioned outputs.
   modport master (
      output sw_high_n, sw_low_n, fault_clear,
      input  state, rise, fall, fault, tick
   );

   // Debouncer side.
   modport slave (
      input  sw_high_n, sw_low_n, fault_clear,
      output state, rise, fall, fault, tick
   );
endinterface

// File: rtl/switch_bank_debouncer.sv
// Front-panel switch conditioner: per-channel synchroniser, SPST/SPDT decode and tick-based
// counter debounce, with registered level, edge pulses and sticky contact-fault flags.
module switch_bank_debouncer #(
   parameter int unsigned         CHANNELS       = 7,
   parameter int unsigned         TICK_DIV       = 366,
   parameter int unsigned         DEBOUNCE_TICKS = 256,
   parameter logic [CHANNELS-1:0] SPDT_MASK      = '1,
   parameter logic [CHANNELS-1:0] INIT_STATE     = '0
) (
   input logic                hwclk,
   input logic                reset,
   switch_bank_debouncer_if.slave bus
);

   // A one-cycle divider still needs a 1-bit register.
   localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_TICKS + 1);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);

   logic [TICK_W-1:0]   div_q, div_d;
   logic                tick_q, tick_d;

   logic [CHANNELS-1:0] high_meta, high_sync;
   logic [CHANNELS-1:0] low_meta, low_sync;

   logic [CHANNELS-1:0] cand_q, cand_d;
   logic [CHANNELS-1:0] state_q, state_d;
   logic [CHANNELS-1:0] rise_q, rise_d;
   logic [CHANNELS-1:0] fall_q, fall_d;
   logic [CHANNELS-1:0] fault_q, fault_d;
   logic [CHANNELS-1:0] fault_set;
   logic [CNT_W-1:0]    cnt_q [CHANNELS];
   logic [CNT_W-1:0]    cnt_d [CHANNELS];

   // Sample-tick divider: tick is registered so it is high exactly while the count sits at its last value.
   always_comb begin
      div_d  = div_q + TICK_W'(1);
      if (div_q == TICK_LAST) begin
         div_d = '0;
      end
      tick_d = (div_d == TICK_LAST);
   end

   // Divider registers.
   always_ff @(posedge hwclk) begin
      if (reset) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
      end
   end

   // Two-flop synchroniser per contact pin; contacts read as open out of reset.
   always_ff @(posedge hwclk) begin
      if (reset) begin
         high_meta <= '1;
         high_sync <= '1;
         low_meta  <= '1;
         low_sync  <= '1;
      end else begin
         high_meta <= bus.sw_high_n;
         high_sync <= high_meta;
         low_meta  <= bus.sw_low_n;
         low_sync  <= low_meta;
      end
   end

   // Per-channel decode and debounce; everything except fault clear advances only on a tick.
   always_comb begin
      cand_d    = cand_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      rise_d    = '0;
      fall_d    = '0;
      fault_set = '0;

      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (tick_q) begin
            if (SPDT_MASK[i]) begin
               // Transit (both open) and both-closed hold the last throw, like the old SR latch.
               case ({high_sync[i], low_sync[i]})
                  2'b01:   cand_d[i] = 1'b1;
                  2'b10:   cand_d[i] = 1'b0;
                  2'b00:   fault_set[i] = 1'b1;
                  default: cand_d[i] = cand_q[i];
               endcase
            end else begin
               cand_d[i] = ~low_sync[i];
            end

            if (cand_d[i] == state_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               state_d[i] = cand_d[i];
               cnt_d[i]   = '0;
               rise_d[i]  = cand_d[i];
               fall_d[i]  = ~cand_d[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end

      // A set on the same cycle as a clear survives.
      fault_d = (fault_q & ~{CHANNELS{bus.fault_clear}}) | fault_set;
   end

   // Channel state registers; reset discards all debounce progress and never emits pulses.
   always_ff @(posedge hwclk) begin
      if (reset) begin
         cand_q  <= INIT_STATE;
         state_q <= INIT_STATE;
         rise_q  <= '0;
         fall_q  <= '0;
         fault_q <= '0;
         for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         cand_q  <= cand_d;
         state_q <= state_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         fault_q <= fault_d;
         for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.state = state_q;
   assign bus.rise  = rise_q;
   assign bus.fall  = fall_q;
   assign bus.fault = fault_q;
   assign bus.tick  = tick_q;

endmodule

// File: tb/tb_switch_bank_debouncer.sv
// Scenario bench for switch_bank_debouncer: expected pulse events are queued at stimulus time
// and matched against pulses captured from the DUT.
module tb_switch_bank_debouncer;

   localparam int unsigned CH = 2;
   localparam int          TD = 4;
   localparam int          DT = 3;

   typedef struct packed {
      logic [31:0]   cyc;
      logic [CH-1:0] rise;
      logic [CH-1:0] fall;
   } event_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   rel_cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   event_t exp_q[$];
   event_t obs_q[$];

   switch_bank_debouncer_if #(.CHANNELS(CH)) bus ();

   switch_bank_debouncer #(
      .CHANNELS       (CH),
      .TICK_DIV       (TD),
      .DEBOUNCE_TICKS (DT),
      .SPDT_MASK      (2'b10),
      .INIT_STATE     (2'b00)
   ) dut (
      .hwclk (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Posedge count: at a negedge, cyc is the number of the posedge just taken.
   always @(posedge clk) cyc <= cyc + 1;

   // Capture every rise/fall pulse with the posedge that produced it.
   always @(negedge clk) begin
      if ((|bus.rise) || (|bus.fall)) obs_q.push_back(event_t'{32'(cyc), bus.rise, bus.fall});
   end

   // First tick edge able to see an input driven after posedge c (two sync flops in between).
   function automatic int first_tick(input int c);
      int k;
      k = c + 3;
      while (((k - rel_cyc) % TD) != 0) k++;
      return k;
   endfunction

   function automatic int flip_cycle(input int c);
      return first_tick(c) + (DT - 1) * TD;
   endfunction

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      rel_cyc = cyc;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      event_t e, o;
      logic exp_tick;
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus.state, bus.rise, bus.fall, bus.fault} !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b want 00000000", {bus.state, bus.rise, bus.fall, bus.fault});
      end
      vectors++;
      if (bus.tick !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_tick: got %b want 0", bus.tick);
      end
      rel_cyc = cyc;
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         exp_tick = (((cyc - rel_cyc) % TD) == TD - 1);
         vectors++;
         if (bus.tick !== exp_tick) begin
            miscompares++;
            $display("FAIL tick_period cyc=%0d: got %b want %b", cyc - rel_cyc, bus.tick, exp_tick);
         end
      end
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL reset_events: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL reset_event: got %0d/%b/%b want %0d/%b/%b", o.cyc, o.rise, o.fall, e.cyc, e.rise, e.fall);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_hold_low();
      event_t e, o;
      int flip;
      bus.sw_low_n[0] = 1'b0;
      flip = flip_cycle(cyc);
      exp_q.push_back(event_t'{32'(flip), 2'b01, 2'b00});
      while (cyc < flip + 3) begin
         @(negedge clk);
         if (cyc == flip - 1) begin
            vectors++;
            if (bus.state !== 2'b00) begin
               miscompares++;
               $display("FAIL hold_early: got %b want 00", bus.state);
            end
         end
         if (cyc == flip) begin
            vectors++;
            if ({bus.state, bus.rise, bus.fall} !== 6'b01_01_00) begin
               miscompares++;
               $display("FAIL hold_flip: got %b want 010100", {bus.state, bus.rise, bus.fall});
            end
         end
      end
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL hold_events: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL hold_event: got %0d/%b/%b want %0d/%b/%b", o.cyc, o.rise, o.fall, e.cyc, e.rise, e.fall);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_bounce();
      event_t e, o;
      for (int i = 0; i < 34; i++) begin
         bus.sw_low_n[0] = ~bus.sw_low_n[0];
         repeat (6) @(negedge clk);
      end
      repeat (20) @(negedge clk);
      vectors++;
      if (bus.state !== 2'b01) begin
         miscompares++;
         $display("FAIL bounce_state: got %b want 01", bus.state);
      end
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL bounce_events: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL bounce_event: got %0d/%b/%b want %0d/%b/%b", o.cyc, o.rise, o.fall, e.cyc, e.rise, e.fall);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_spdt();
      event_t e, o;
      int flip;
      bus.sw_high_n[1] = 1'b0;
      flip = flip_cycle(cyc);
      exp_q.push_back(event_t'{32'(flip), 2'b10, 2'b00});
      while (cyc < flip + 2) begin
         @(negedge clk);
         if (cyc == flip) begin
            vectors++;
            if ({bus.state, bus.rise} !== 4'b11_10) begin
               miscompares++;
               $display("FAIL spdt_high: got %b want 1110", {bus.state, bus.rise});
            end
         end
      end
      bus.sw_high_n[1] = 1'b1;
      repeat (100) @(negedge clk);
      vectors++;
      if (bus.state !== 2'b11) begin
         miscompares++;
         $display("FAIL spdt_transit: got %b want 11", bus.state);
      end
      bus.sw_low_n[1] = 1'b0;
      flip = flip_cycle(cyc);
      exp_q.push_back(event_t'{32'(flip), 2'b00, 2'b10});
      while (cyc < flip + 2) begin
         @(negedge clk);
         if (cyc == flip) begin
            vectors++;
            if ({bus.state, bus.fall} !== 4'b01_10) begin
               miscompares++;
               $display("FAIL spdt_low: got %b want 0110", {bus.state, bus.fall});
            end
         end
      end
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL spdt_events: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL spdt_event: got %0d/%b/%b want %0d/%b/%b", o.cyc, o.rise, o.fall, e.cyc, e.rise, e.fall);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_fault();
      event_t e, o;
      int k;
      int guard;
      bus.sw_high_n[1] = 1'b0;
      k = first_tick(cyc);
      while (cyc < k + 1) begin
         @(negedge clk);
         if (cyc == k - 1) begin
            vectors++;
            if (bus.fault !== 2'b00) begin
               miscompares++;
               $display("FAIL fault_early: got %b want 00", bus.fault);
            end
         end
         if (cyc == k) begin
            vectors++;
            if ({bus.fault, bus.state} !== 4'b10_01) begin
               miscompares++;
               $display("FAIL fault_set: got %b want 1001", {bus.fault, bus.state});
            end
         end
      end
      // Line the clear up with a tick edge so it collides with a fresh set.
      guard = 0;
      while (bus.tick !== 1'b1 && guard < 2 * TD) begin
         @(negedge clk);
         guard++;
      end
      vectors++;
      if (bus.tick !== 1'b1) begin
         miscompares++;
         $display("FAIL fault_tick_wait: got %b want 1", bus.tick);
      end
      bus.fault_clear = 1'b1;
      @(negedge clk);
      bus.fault_clear = 1'b0;
      vectors++;
      if (bus.fault !== 2'b10) begin
         miscompares++;
         $display("FAIL fault_set_wins: got %b want 10", bus.fault);
      end
      bus.sw_high_n[1] = 1'b1;
      repeat (4) @(negedge clk);
      bus.fault_clear = 1'b1;
      @(negedge clk);
      bus.fault_clear = 1'b0;
      vectors++;
      if (bus.fault !== 2'b00) begin
         miscompares++;
         $display("FAIL fault_clear: got %b want 00", bus.fault);
      end
      repeat (10) @(negedge clk);
      vectors++;
      if ({bus.fault, bus.state} !== 4'b00_01) begin
         miscompares++;
         $display("FAIL fault_after: got %b want 0001", {bus.fault, bus.state});
      end
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL fault_events: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL fault_event: got %0d/%b/%b want %0d/%b/%b", o.cyc, o.rise, o.fall, e.cyc, e.rise, e.fall);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_midway();
      event_t e, o;
      int k;
      int flip;
      // Reset drops state[0] from 1 to 0 without a fall pulse.
      bus.sw_low_n[0] = 1'b1;
      do_reset(2);
      vectors++;
      if (bus.state !== 2'b00) begin
         miscompares++;
         $display("FAIL midway_reset_state: got %b want 00", bus.state);
      end
      bus.sw_low_n[0] = 1'b0;
      k = first_tick(cyc);
      while (cyc < k + TD) @(negedge clk);
      vectors++;
      if (bus.state !== 2'b00) begin
         miscompares++;
         $display("FAIL midway_two_ticks: got %b want 00", bus.state);
      end
      do_reset(1);
      flip = flip_cycle(rel_cyc);
      exp_q.push_back(event_t'{32'(flip), 2'b01, 2'b00});
      while (cyc < flip + 2) begin
         @(negedge clk);
         if (cyc == flip - 1) begin
            vectors++;
            if (bus.state !== 2'b00) begin
               miscompares++;
               $display("FAIL midway_early: got %b want 00", bus.state);
            end
         end
         if (cyc == flip) begin
            vectors++;
            if (bus.state !== 2'b01) begin
               miscompares++;
               $display("FAIL midway_flip: got %b want 01", bus.state);
            end
         end
      end
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL midway_events: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL midway_event: got %0d/%b/%b want %0d/%b/%b", o.cyc, o.rise, o.fall, e.cyc, e.rise, e.fall);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_back_to_back();
      event_t e, o;
      int flip;
      bus.sw_low_n[0]  = 1'b1;
      bus.sw_high_n[1] = 1'b0;
      bus.sw_low_n[1]  = 1'b1;
      flip = flip_cycle(cyc);
      exp_q.push_back(event_t'{32'(flip), 2'b10, 2'b01});
      while (cyc < flip + 3) begin
         @(negedge clk);
         if (cyc == flip) begin
            vectors++;
            if (bus.state !== 2'b10) begin
               miscompares++;
               $display("FAIL b2b_state: got %b want 10", bus.state);
            end
         end
      end
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL b2b_events: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL b2b_event: got %0d/%b/%b want %0d/%b/%b", o.cyc, o.rise, o.fall, e.cyc, e.rise, e.fall);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      reset           = 1'b1;
      bus.sw_high_n   = '1;
      bus.sw_low_n    = '1;
      bus.fault_clear = 1'b0;
      test_reset();
      test_hold_low();
      test_bounce();
      test_spdt();
      test_fault();
      test_reset_midway();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
